pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard and forwarding controller for the 5-stage pipeline (IF, ID, EX, MEM, WR). It succeeds the per-stage stall stub.
- Tracks in-flight destination registers in an internal shadow pipeline. From that it produces registered forwarding selects for the EX operands, load-use stalls and bubbles, and taken-branch flushes.
- Keeps saturating stall and flush performance counters.
- Sits beside the ID stage. It drives the IF/ID and ID/EX register enables and the operand-source muxes in EX.

Parameters:
- REG_AW, 5, register address width; register 0 is hardwired zero and never causes a hazard.
- FWD_DEPTH, 2, number of post-EX stages that can forward (default: EX/MEM, MEM/WR).
- LOAD_READY, 2, shadow index at which load data first becomes forwardable; range 1..FWD_DEPTH.
- FWD_SEL_W, $clog2(FWD_DEPTH+1), width of the forwarding selects.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on negedge clk, matching the pipeline registers.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt  in  REG_AW  ID source registers.
- id_use_rs, id_use_rt  in  1  the instruction actually reads that operand.
- id_reg_wr  in  1  the instruction writes a register.
- id_rw  in  REG_AW  the instruction's destination register.
- id_is_load  in  1  the instruction is lw.
- ex_br_taken  in  1  the branch in EX resolved taken.
- if_stall  out  1  hold the PC and IF/ID.
- id_stall  out  1  hold the ID instruction.
- id_bubble  out  1  load a NOP (RegWr=0, MemWr=0) into ID/EX.
- flush_if_id  out  1  zero IF/ID on the next edge.
- fwd_a_sel, fwd_b_sel  out  FWD_SEL_W  EX operand source: 0 = register file; k = shadow stage k.
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters.

Behaviour:
- Shadow pipeline:
  - Entries sh[0..FWD_DEPTH], each {valid, rw, is_load}. sh[0] is the instruction in EX; sh[FWD_DEPTH] is the one in WR.
  - On each edge sh[k+1] <= sh[k].
  - sh[0] <= {id_valid & id_reg_wr & (id_rw != 0) & ~id_bubble & ~flush, id_rw, id_is_load}.
- Match definition: id_rs matches sh[k] iff sh[k].valid, id_use_rs and id_rs == sh[k].rw. Same rule for rt.
- Load-use stall (combinational):
  - Condition: a match on sh[k] with sh[k].is_load and k+1 < LOAD_READY.
  - Response: if_stall = id_stall = id_bubble = 1.
  - Default parameters give exactly 1 stall cycle for lw immediately followed by a consumer.
- Forwarding (registered, valid while the consumer is in EX):
  - On an edge with no stall, fwd_x_sel <= the smallest j in 1..FWD_DEPTH such that the operand matches post-shift sh[j] (the pre-shift sh[j-1]).
  - A load at j is only eligible if j >= LOAD_READY.
  - If there is no match, or a stall or flush occurs, fwd_x_sel <= 0.
  - The youngest producer always wins when several match.
- Branch flush:
  - ex_br_taken = 1 asserts flush_if_id and id_bubble in the same cycle, squashing the two younger instructions.
  - The squashed ID entry does not enter the shadow pipeline.
  - The branch itself keeps its shadow entry.
- Simultaneous flush and load-use: the flush wins.
  - if_stall = id_stall = 0 (the new PC must load) and id_bubble = 1.
  - stall_cnt is not incremented; flush_cnt is.
- Counters:
  - stall_cnt increments on each edge where if_stall = 1.
  - flush_cnt increments on each edge where ex_br_taken = 1.
  - Both saturate at all-ones; there is no wrap.
- Reset:
  - All shadow entries go invalid; fwd selects = 0; counters = 0.
  - Combinational outputs evaluate to 0 because the shadow is empty and ex_br_taken is gated by ~rst.
  - Reset mid-stall clears immediately; the first post-reset cycle has no stall.

Decomposition:
- Shared package pipe_pkg:
  - FWD_RF = 0 constant.
  - Shadow entry typedef {valid, rw, is_load}.
  - The REG_AW default.
- One natural sub-module: sat_counter (CNT_W parameter, inc/rst, saturating). It is instantiated twice.

Test Plan:
1. add r3 at cycle 0, then `sub r4,r3,r1` next → no stall; fwd_a_sel = 1 while the sub is in EX; fwd_b_sel = 0.
2. lw r5, then `add r6,r5,r5` → one cycle of if_stall = id_stall = id_bubble = 1; then fwd_a_sel = fwd_b_sel = 2; stall_cnt = 1.
3. add r7; an unrelated instruction; then `or r8,r7,r0` → fwd_a_sel = 2; r0 never matches, so fwd_b_sel = 0.
4. lw r9 in EX while the ID consumer reads r9 and ex_br_taken = 1 in the same cycle → flush_if_id = 1, id_bubble = 1, if_stall = 0; stall_cnt unchanged; flush_cnt = 1.
5. rst pulsed asynchronously mid-stall (between edges) → if_stall drops immediately; fwd selects and counters = 0; the next add/consumer pair produces no false forward.
6. FWD_DEPTH = 3, LOAD_READY = 3, lw followed by a consumer → 2 stall cycles, then fwd_sel = 3; force 65535 stalls → stall_cnt holds at 16'hFFFF.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants and types for the pipeline hazard/forwarding logic.
//   REG_AW_DFLT : default register address width
//   FWD_RF      : forwarding select value meaning "read the register file"
//   sh_entry_t  : one shadow-pipeline entry at the default register width
package pipe_pkg;

  localparam int REG_AW_DFLT = 5;
  localparam int FWD_RF      = 0;

  typedef struct packed {
    logic                   valid;
    logic [REG_AW_DFLT-1:0] rw;
    logic                   is_load;
  } sh_entry_t;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping.
// State advances on the falling clock edge, like the pipeline registers.
//   clk, rst : clock, async active-high reset (clears to 0)
//   i_inc    : count this edge
//   o_cnt    : current count
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(negedge clk or posedge rst) begin
    if (rst)                          r_cnt <= '0;
    else if (i_inc && (r_cnt != '1))  r_cnt <= r_cnt + CNT_W'(1);
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and forwarding controller for a 5-stage pipeline.
// A shadow pipeline of destination registers (sh[0] = EX .. sh[FWD_DEPTH] = WR)
// drives load-use stalls, taken-branch flushes and registered EX forwarding
// selects. State advances on the falling clock edge.
//   clk, rst                 : clock, async active-high reset
//   id_valid/id_rs/id_rt     : ID instruction and its source registers
//   id_use_rs/id_use_rt      : operand actually read
//   id_reg_wr/id_rw          : register write and its destination
//   id_is_load               : ID instruction is a load
//   ex_br_taken              : branch in EX resolved taken
//   if_stall/id_stall        : hold PC, IF/ID and the ID instruction
//   id_bubble                : insert a NOP into ID/EX
//   flush_if_id              : zero IF/ID on the next edge
//   fwd_a_sel/fwd_b_sel      : EX operand source (0 = RF, k = shadow stage k)
//   stall_cnt/flush_cnt      : saturating event counters
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW     = REG_AW_DFLT,
  parameter int FWD_DEPTH  = 2,
  parameter int LOAD_READY = 2,
  parameter int FWD_SEL_W  = $clog2(FWD_DEPTH + 1),
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [REG_AW-1:0]    id_rs,
  input  logic [REG_AW-1:0]    id_rt,
  input  logic                 id_use_rs,
  input  logic                 id_use_rt,
  input  logic                 id_reg_wr,
  input  logic [REG_AW-1:0]    id_rw,
  input  logic                 id_is_load,
  input  logic                 ex_br_taken,
  output logic                 if_stall,
  output logic                 id_stall,
  output logic                 id_bubble,
  output logic                 flush_if_id,
  output logic [FWD_SEL_W-1:0] fwd_a_sel,
  output logic [FWD_SEL_W-1:0] fwd_b_sel,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  // Same layout as sh_entry_t, sized to this instance's register width.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rw;
    logic              is_load;
  } sh_t;

  sh_t [FWD_DEPTH:0]    r_sh;
  logic [FWD_SEL_W-1:0] r_fwd_a, r_fwd_b;

  logic                 w_flush, w_lu;
  logic [FWD_DEPTH:0]   w_m_rs, w_m_rt, w_ld;
  logic [FWD_SEL_W-1:0] w_fwd_a, w_fwd_b;

  // Youngest eligible producer wins: scan from oldest to youngest so the
  // last hit is the smallest j. A load only qualifies once its data exists.
  function automatic logic [FWD_SEL_W-1:0] fwd_pick(input logic [FWD_DEPTH:0] m,
                                                    input logic [FWD_DEPTH:0] ld);
    logic [FWD_SEL_W-1:0] sel;
    sel = FWD_SEL_W'(FWD_RF);
    for (int j = FWD_DEPTH; j >= 1; j--) begin
      if (m[j-1] && (!ld[j-1] || (j >= LOAD_READY))) sel = FWD_SEL_W'(j);
    end
    return sel;
  endfunction

  // Gate with reset so outputs are quiet while reset is held.
  assign w_flush = ex_br_taken & ~rst;

  always_comb begin
    w_m_rs = '0;
    w_m_rt = '0;
    w_ld   = '0;
    w_lu   = 1'b0;
    for (int k = 0; k <= FWD_DEPTH; k++) begin
      w_m_rs[k] = r_sh[k].valid & id_use_rs & (id_rs == r_sh[k].rw);
      w_m_rt[k] = r_sh[k].valid & id_use_rt & (id_rt == r_sh[k].rw);
      w_ld[k]   = r_sh[k].is_load;
      // Load whose data is not yet forwardable when the consumer reaches EX.
      if ((k + 1) < LOAD_READY) w_lu = w_lu | (w_ld[k] & (w_m_rs[k] | w_m_rt[k]));
    end
    w_fwd_a = fwd_pick(w_m_rs, w_ld);
    w_fwd_b = fwd_pick(w_m_rt, w_ld);
  end

  // A flush overrides a load-use stall: the redirected PC must still load.
  assign if_stall    = w_lu & ~w_flush;
  assign id_stall    = w_lu & ~w_flush;
  assign id_bubble   = w_lu | w_flush;
  assign flush_if_id = w_flush;

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_sh    <= '0;
      r_fwd_a <= '0;
      r_fwd_b <= '0;
    end else begin
      r_sh[0] <= sh_t'{valid:   id_valid & id_reg_wr & (id_rw != '0) & ~id_bubble & ~w_flush,
                       rw:      id_rw,
                       is_load: id_is_load};
      for (int k = 0; k < FWD_DEPTH; k++) r_sh[k+1] <= r_sh[k];
      if (if_stall || w_flush) begin
        r_fwd_a <= FWD_SEL_W'(FWD_RF);
        r_fwd_b <= FWD_SEL_W'(FWD_RF);
      end else begin
        r_fwd_a <= w_fwd_a;
        r_fwd_b <= w_fwd_b;
      end
    end
  end

  assign fwd_a_sel = r_fwd_a;
  assign fwd_b_sel = r_fwd_b;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (if_stall),
    .o_cnt (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_flush),
    .o_cnt (flush_cnt)
  );

endmodule
